uart_word_tx: RTL

//  Synthesizable 8N1 UART transmitter; the DUT-side sender for the bench UART receiver model.

---
 rtl/uart_word_tx_pkg.sv | 40 ++++
 rtl/uart_tx_byte.sv | 107 ++++++++++
 rtl/uart_word_tx.sv | 89 ++++++++
 3 files changed

// File: rtl/uart_word_tx_pkg.sv
// Shared UART framing constants, FSM state types and the frame byte selector.
// Intended for reuse by a future word receiver.
package uart_word_tx_pkg;

  localparam logic [7:0]  CR_BYTE          = 8'h0D;
  localparam logic [7:0]  SEP_BYTE_DEFAULT = 8'h0A;
  localparam int unsigned FRAME_LEN        = 6;
  localparam int unsigned IDX_W            = 3;

  typedef logic [IDX_W-1:0] byte_idx_t;

  localparam byte_idx_t LAST_IDX = byte_idx_t'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    BYTE_IDLE,
    BYTE_START,
    BYTE_DATA,
    BYTE_STOP
  } byte_state_t;

  typedef enum logic {
    FRAME_IDLE,
    FRAME_SEND
  } frame_state_t;

  // Frame layout: four word bytes LSB first, separator, then CR.
  function automatic logic [7:0] frame_byte(input logic [31:0] word,
                                            input byte_idx_t   idx,
                                            input logic [7:0]  sep);
    case (idx)
      3'd0:    frame_byte = word[7:0];
      3'd1:    frame_byte = word[15:8];
      3'd2:    frame_byte = word[23:16];
      3'd3:    frame_byte = word[31:24];
      3'd4:    frame_byte = sep;
      default: frame_byte = CR_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: START, D0..D7 LSB first, STOP, each CLKS_PER_BIT cycles.
// A start request seen on the last stop cycle chains the next byte with no idle gap.
module uart_tx_byte
  import uart_word_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       done,
  output logic       tx
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  byte_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             tx_n;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    done      = 1'b0;
    case (state)
      BYTE_IDLE: begin
        if (start) begin
          state_n = BYTE_START;
          cnt_n   = '0;
          shreg_n = data;
        end
      end
      BYTE_START: begin
        if (bit_end) begin
          state_n   = BYTE_DATA;
          cnt_n     = '0;
          bit_idx_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BYTE_DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shreg_n = shreg >> 1;
          if (bit_idx == 3'd7) begin
            state_n = BYTE_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        if (bit_end) begin
          done  = 1'b1;
          cnt_n = '0;
          if (start) begin
            state_n = BYTE_START;
            shreg_n = data;
          end else begin
            state_n = BYTE_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

  // Line level follows the state being entered so tx comes straight off a flop.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      BYTE_START: tx_n = 1'b0;
      BYTE_DATA:  tx_n = shreg_n[0];
      default:    tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BYTE_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Word-to-UART sender: latches a 32-bit word per handshake and emits the
// 6-byte frame word[7:0]..word[31:24], SEP_BYTE, CR over one byte serializer.
module uart_word_tx
  import uart_word_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter logic [7:0]  SEP_BYTE     = SEP_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy
);

  frame_state_t state, state_n;
  byte_idx_t    idx, idx_n, data_idx;
  logic [31:0]  word_q, word_n;
  logic         launch, launch_n;
  logic         byte_done;
  logic         byte_start;
  logic [7:0]   byte_data;

  assign word_ready = (state == FRAME_IDLE);
  assign busy       = (state == FRAME_SEND);

  // The serializer loads the following byte on the same edge its stop bit ends,
  // so the mux looks one index ahead while done is high.
  assign byte_start = launch || (byte_done && idx != LAST_IDX);
  assign data_idx   = (byte_done && idx != LAST_IDX) ? idx + 3'd1 : idx;
  assign byte_data  = frame_byte(word_q, data_idx, SEP_BYTE);

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    word_n   = word_q;
    launch_n = 1'b0;
    case (state)
      FRAME_IDLE: begin
        if (word_valid) begin
          state_n  = FRAME_SEND;
          idx_n    = '0;
          word_n   = word_in;
          launch_n = 1'b1;
        end
      end
      default: begin
        if (byte_done) begin
          if (idx == LAST_IDX) begin
            state_n = FRAME_IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FRAME_IDLE;
      idx    <= '0;
      word_q <= '0;
      launch <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      word_q <= word_n;
      launch <= launch_n;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .rst  (rst),
    .data (byte_data),
    .start(byte_start),
    .done (byte_done),
    .tx   (tx)
  );

endmodule
